// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic elastic pipeline stage register with a 2-entry skid buffer.
//   The payload is split into control bits (forced to zero on bubbles) and
//   data bits (hold their last value on bubbles). All state changes on the
//   falling clock edge. o_ready is registered, so there is no combinational
//   path from i_ready to o_ready.
//
//   Optional feature macro: PIPE_STAGE_STATS_EN
//     defined   -> o_stall_cycles counts i_step & o_valid & !i_ready edges,
//                  saturating at all-ones; cleared only by reset.
//     undefined -> o_stall_cycles tied to 0, no counter logic.
//
// Ports
//   i_clk          clock (state updates on falling edge)
//   i_reset_n      asynchronous active-low reset
//   i_step         global step enable; 0 freezes all state
//   i_flush        synchronous flush of held entries and same-cycle input
//   i_valid        upstream beat present
//   o_ready        stage can accept a beat (registered)
//   i_ctrl/i_data  upstream payload
//   o_valid        head beat present for downstream
//   i_ready        downstream accepts
//   o_ctrl/o_data  head payload (o_ctrl = 0 when !o_valid)
//   o_count        entries held (0..2)
//   o_stall_cycles downstream-stall counter
module pipe_stage_skid #(
  parameter int NB_DATA = 32,
  parameter int NB_CTRL = 8,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_step,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data,
  output logic [1:0]         o_count,
  output logic [NB_CNT-1:0]  o_stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               ready_q, ready_nxt;
  logic [NB_CTRL-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
  logic [NB_DATA-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
  logic               acc_in, acc_out;

  assign o_valid = (state != ST_EMPTY);
  assign o_ready = ready_q;
  assign o_ctrl  = o_valid ? main_ctrl : '0;
  assign o_data  = main_data;
  assign acc_in  = i_step & i_valid & ready_q;
  assign acc_out = i_step & o_valid & i_ready;

  always_comb begin
    o_count = 2'd0;
    case (state)
      ST_ONE:  o_count = 2'd1;
      ST_FULL: o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

  // Next-state: main register is always the head; skid only fills when the
  // head is blocked while a new beat arrives.
  always_comb begin
    state_nxt     = state;
    main_ctrl_nxt = main_ctrl;
    main_data_nxt = main_data;
    skid_ctrl_nxt = skid_ctrl;
    skid_data_nxt = skid_data;
    if (i_step && i_flush) begin
      // Flush wins over any same-edge transfer; payload registers keep
      // their contents so o_data still shows the last head.
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc_in) begin
            state_nxt     = ST_ONE;
            main_ctrl_nxt = i_ctrl;
            main_data_nxt = i_data;
          end
        end
        ST_ONE: begin
          if (acc_in && !acc_out) begin
            state_nxt     = ST_FULL;
            skid_ctrl_nxt = i_ctrl;
            skid_data_nxt = i_data;
          end else if (acc_in && acc_out) begin
            main_ctrl_nxt = i_ctrl;
            main_data_nxt = i_data;
          end else if (acc_out) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (acc_out) begin
            state_nxt     = ST_ONE;
            main_ctrl_nxt = skid_ctrl;
            main_data_nxt = skid_data;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
    ready_nxt = (state_nxt != ST_FULL);
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_EMPTY;
      ready_q   <= 1'b1;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      ready_q   <= ready_nxt;
      main_ctrl <= main_ctrl_nxt;
      main_data <= main_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      skid_data <= skid_data_nxt;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (v == '1) ? v : v + NB_CNT'(1);
  endfunction

  logic [NB_CNT-1:0] stall_q;

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_q <= '0;
    end else if (i_step && o_valid && !i_ready) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int NB_DATA = 32;
  localparam int NB_CTRL = 8;
  localparam int NB_CNT  = 4;
  localparam int MAXC    = (1 << NB_CNT) - 1;
`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b1;
  logic               i_step = 1'b1;
  logic               i_flush = 1'b0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic [NB_CTRL-1:0] i_ctrl = '0;
  logic [NB_DATA-1:0] i_data = '0;
  logic               o_valid;
  logic               i_ready = 1'b0;
  logic [NB_CTRL-1:0] o_ctrl;
  logic [NB_DATA-1:0] o_data;
  logic [1:0]         o_count;
  logic [NB_CNT-1:0]  o_stall_cycles;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 i_clk = ~i_clk;

  pipe_stage_skid #(.NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_ctrl(o_ctrl), .o_data(o_data),
    .o_count(o_count), .o_stall_cycles(o_stall_cycles)
  );

  // Reference model: a FIFO of beats with capacity two, a registered
  // "room available" flag, the last head data, and a saturating stall count.
  logic [NB_CTRL+NB_DATA-1:0] q[$];
  bit                         m_ready = 1'b1;
  logic [NB_DATA-1:0]         m_data = '0;
  int                         m_stall = 0;

  initial forever begin
    @(negedge i_clk or negedge i_reset_n);
    if (!i_reset_n) begin
      q.delete();
      m_ready = 1'b1;
      m_data  = '0;
      m_stall = 0;
    end else begin
      bit v, a_in, a_out;
      v     = (q.size() > 0);
      a_in  = i_step && i_valid && m_ready;
      a_out = i_step && v && i_ready;
      if (i_step && v && !i_ready && m_stall < MAXC) m_stall++;
      if (i_step && i_flush) begin
        q.delete();
      end else begin
        if (a_out) void'(q.pop_front());
        if (a_in) q.push_back({i_ctrl, i_data});
      end
      m_ready = (q.size() < 2);
      if (q.size() > 0) begin
        logic [NB_CTRL+NB_DATA-1:0] h;
        h = q[0];
        m_data = h[NB_DATA-1:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the falling edge.
  initial forever begin
    @(posedge i_clk);
    if (check_en) begin
      logic [NB_CTRL+NB_DATA-1:0] h;
      logic [NB_CTRL-1:0]         ec;
      ec = '0;
      if (q.size() > 0) begin
        h  = q[0];
        ec = h[NB_CTRL+NB_DATA-1:NB_DATA];
      end
      chk("m_valid", o_valid, (q.size() > 0));
      chk("m_ctrl", o_ctrl, ec);
      chk("m_data", o_data, m_data);
      chk("m_ready", o_ready, m_ready);
      chk("m_count", o_count, q.size());
      chk("m_stall", o_stall_cycles, STATS ? m_stall : 0);
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [31:0] d);
    i_valid = 1'b1;
    i_ctrl  = c;
    i_data  = d;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ctrl"}, o_ctrl, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_stall"}, o_stall_cycles, 0);
  endtask

  initial begin
    int rpct;
    #2 i_reset_n = 1'b0;
    #1 reset_checks("rst0");
    check_en = 1'b1;
    cyc();
    i_reset_n = 1'b1;
    cyc();

    // Streaming
    i_ready = 1'b1;
    push(8'h01, 32'd1); cyc();
    chk("st_d1", o_data, 1); chk("st_cnt1", o_count, 1); chk("st_rdy1", o_ready, 1);
    push(8'h01, 32'd2); cyc();
    chk("st_d2", o_data, 2);
    push(8'h01, 32'd3); cyc();
    chk("st_d3", o_data, 3); chk("st_cnt3", o_count, 1); chk("st_rdy3", o_ready, 1);
    i_valid = 1'b0; cyc();
    chk("st_empty", o_count, 0); chk("st_hold", o_data, 3); chk("st_bub", o_ctrl, 0);

    // Backpressure
    i_ready = 1'b0;
    push(8'h05, 32'h11); cyc();
    push(8'h06, 32'h22); cyc();
    i_valid = 1'b0;
    chk("bp_cnt", o_count, 2); chk("bp_rdy", o_ready, 0);
    chk("bp_data", o_data, 32'h11); chk("bp_ctrl", o_ctrl, 8'h05);
    i_ready = 1'b1; cyc();
    chk("bp_pop_d", o_data, 32'h22); chk("bp_pop_r", o_ready, 1); chk("bp_pop_c", o_count, 1);
    cyc();
    chk("bp_done", o_count, 0);

    // Flush from FULL with a same-cycle input
    i_ready = 1'b0;
    push(8'hFF, 32'hAA); cyc();
    push(8'hFF, 32'hBB); cyc();
    chk("fl_full", o_count, 2); chk("fl_ctrl", o_ctrl, 8'hFF);
    i_flush = 1'b1; push(8'hFF, 32'h33); cyc();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("fl_valid", o_valid, 0); chk("fl_ctrl0", o_ctrl, 0);
    chk("fl_cnt", o_count, 0); chk("fl_rdy", o_ready, 1); chk("fl_data", o_data, 32'hAA);
    i_ready = 1'b1; cyc();
    chk("fl_no33", o_data, 32'hAA);

    // Step freeze
    i_ready = 1'b0;
    push(8'h02, 32'h44); cyc();
    i_step = 1'b0; i_ready = 1'b1; push(8'h03, 32'h55);
    repeat (5) begin
      cyc();
      chk("fz_cnt", o_count, 1); chk("fz_data", o_data, 32'h44);
    end
    i_step = 1'b1; cyc();
    chk("fz_res_d", o_data, 32'h55); chk("fz_res_c", o_count, 1);
    i_valid = 1'b0; cyc();
    chk("fz_empty", o_count, 0);

    // Stall statistics and saturation
    i_ready = 1'b0;
    push(8'h07, 32'h66); cyc();
    i_valid = 1'b0;
    repeat (20) cyc();
    chk("stat_sat", o_stall_cycles, STATS ? 15 : 0);
    i_flush = 1'b1; cyc();
    i_flush = 1'b0;
    chk("stat_flush", o_stall_cycles, STATS ? 15 : 0);
    chk("stat_fl_v", o_valid, 0);

    // Asynchronous reset in the middle of a cycle while holding a beat
    push(8'h08, 32'h77); cyc();
    i_valid = 1'b0;
    chk("mid_pre", o_valid, 1);
    #2 i_reset_n = 1'b0;
    #1 reset_checks("rst_mid");
    cyc();
    i_reset_n = 1'b1;
    cyc();

    // Randomized traffic in segments with different downstream pressure
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0: rpct = 70;
        1: rpct = 25;
        2: rpct = 50;
        default: rpct = 90;
      endcase
      repeat (800) begin
        i_step  = ($urandom_range(0, 7) != 0);
        i_flush = ($urandom_range(0, 31) == 0);
        i_valid = ($urandom_range(0, 99) < 60);
        i_ready = ($urandom_range(0, 99) < rpct);
        i_ctrl  = NB_CTRL'($urandom);
        i_data  = $urandom;
        cyc();
      end
      if (seg < 3) begin
        #3 i_reset_n = 1'b0;
        #1 reset_checks("rst_rnd");
        cyc();
        i_reset_n = 1'b1;
      end
    end

    i_step = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    repeat (4) cyc();
    chk("final_empty", o_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
